ddr3_cmd_monitor: RTL and testbench
===================================

DDR3_CMD_MONITOR -- requirements
Module: ddr3_cmd_monitor

Interface
REQ-001 Parameter BA_W, default 3, bank-address width.
REQ-002 Parameter ADDR_W, default 14, row/column address width.
REQ-003 Parameter T_RCD, default 6, min cycles ACT->RD/WR on the same bank.
REQ-004 Parameter T_RP, default 6, min cycles PRE->ACT on the same bank.
REQ-005 Parameter T_RAS, default 15, min cycles ACT->PRE on the same bank.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  memory clock, DDR3-side ck_p.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 cke, cs_n, ras_n, cas_n, we_n  in  1 each  DDR3-side control pins, after PCB delay.
REQ-010 ba  in  BA_W  bank address; addr  in  ADDR_W  address pins.
REQ-011 cmd_valid  out  1  decoded non-NOP command strobe.
REQ-012 cmd_code  out  4  command enum; cmd_ba  out  BA_W; cmd_addr  out  ADDR_W.
REQ-013 bank_open  out  2**BA_W  per-bank open flag.
REQ-014 err_valid  out  1  protocol-error strobe; err_code  out  4  error enum; err_ba  out  BA_W.
REQ-015 cnt_act, cnt_rd, cnt_wr  out  32 each  saturating command counters.

Function
REQ-016 Sample pins on rising clk; command active only when cke=1 and cs_n=0, else NOP.
REQ-017 Decode {ras_n,cas_n,we_n}: 011 ACT, 101 RD, 100 WR, 010 PRE (addr[10]=1 PREA), 001 REF, 000 MRS, 110 ZQ, 111 NOP.
REQ-018 All outputs registered; cmd_*, err_*, bank_open and counters update exactly 1 cycle after the sampling edge.
REQ-019 cmd_valid and err_valid are single-cycle pulses; at most one command and one error per cycle.
REQ-020 Per-bank FSM CLOSED/OPEN: ACT CLOSED->OPEN; PRE on that bank or PREA OPEN->CLOSED; other commands hold state.
REQ-021 Per-bank 8-bit counters since last ACT and since last PRE, incrementing every cycle, saturating at 255, cleared on the respective command.
REQ-022 Errors: ACT to OPEN bank (ACT_OPEN); RD/WR to CLOSED bank (RW_CLOSED); REF with any bank open (REF_OPEN); RD/WR with act-count < T_RCD (TRCD); ACT with pre-count < T_RP (TRP); PRE of OPEN bank with act-count < T_RAS (TRAS).
REQ-023 Error priority when several apply: ACT_OPEN, RW_CLOSED, REF_OPEN, TRCD, TRP, TRAS.
REQ-024 State errors still apply the state transition (ACT to OPEN bank stays OPEN, restarts act-count).
REQ-025 PREA checks TRAS on every OPEN bank; err_ba reports lowest violating bank.
REQ-026 PRE to CLOSED bank: legal, no error, pre-count cleared.
REQ-027 Counters saturate at 2**32-1, never wrap.

Reset
REQ-028 On rst: cmd_valid=0, err_valid=0, cmd_code=NOP, err_code=NONE, cmd_ba/cmd_addr/err_ba=0, bank_open=0, counters=0.
REQ-029 On rst: per-bank act- and pre-counts set to 255 so the first ACT raises no TRP error.
REQ-030 rst asserted mid-sequence discards in-flight decode; no pulse emitted in the cycle after rst.

Structure
REQ-031 Package ddr3_mon_pkg holds cmd enum, err enum, and command-decode function.
REQ-032 Sub-module ddr3_bank_tracker (FSM plus two counters, one bank) instantiated 2**BA_W times by generate.

Verification
REQ-033 ACT ba=2 row=0x1A5, 6 NOPs, RD col=0x040 -> cmd pulses ACT then RD, bank_open[2]=1, no error, cnt_act=1, cnt_rd=1.
REQ-034 ACT ba=1, RD ba=1 after 3 cycles -> err_valid, err_code=TRCD, err_ba=1.
REQ-035 WR ba=5 with bank closed -> err_code=RW_CLOSED, err_ba=5, bank_open unchanged 0.
REQ-036 ACT ba=0 and ba=3, 20 NOPs, PREA -> bank_open=0 one cycle later; then REF -> no error.
REQ-037 ACT ba=4, REF 2 cycles later -> err_code=REF_OPEN; PRE ba=4 at cycle 10 -> err_code=TRAS.
REQ-038 rst pulsed one cycle after ACT ba=6 -> bank_open=0, all counters 0, immediate ACT ba=6 -> no error.

Source files
------------

// File: rtl/ddr3_mon_pkg.sv
// ddr3_mon_pkg: command/error/bank-state enums plus pin decode and saturating helpers for the DDR3 command monitor
package ddr3_mon_pkg;
  typedef enum logic [3:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF, CMD_MRS, CMD_ZQ} cmd_e;
  typedef enum logic [3:0] {ERR_NONE, ERR_ACT_OPEN, ERR_RW_CLOSED, ERR_REF_OPEN, ERR_TRCD, ERR_TRP, ERR_TRAS} err_e;
  typedef enum logic {BANK_CLOSED, BANK_OPEN} bank_state_e;
  function automatic cmd_e decode_cmd(input logic cke, input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n, input logic a10);
    if (!cke || cs_n) return CMD_NOP;
    case ({ras_n, cas_n, we_n})
      3'b011:  return CMD_ACT;
      3'b101:  return CMD_RD;
      3'b100:  return CMD_WR;
      3'b010:  return a10 ? CMD_PREA : CMD_PRE;
      3'b001:  return CMD_REF;
      3'b000:  return CMD_MRS;
      3'b110:  return CMD_ZQ;
      default: return CMD_NOP;
    endcase
  endfunction
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return c == 8'hff ? c : c + 8'd1;
  endfunction
  function automatic logic [31:0] sat_inc32(input logic [31:0] c, input logic hit);
    return hit && c != '1 ? c + 32'd1 : c;
  endfunction
endpackage

// File: rtl/ddr3_bank_tracker.sv
// ddr3_bank_tracker: open/closed state of one bank plus saturating cycle counts since its last ACT and PRE
module ddr3_bank_tracker
  import ddr3_mon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       act,
  input  logic       pre,
  output logic       is_open,
  output logic [7:0] act_cnt,
  output logic [7:0] pre_cnt
);
  bank_state_e state_q, state_d;
  logic [7:0] act_cnt_q, act_cnt_d, pre_cnt_q, pre_cnt_d;
  always_comb begin
    state_d   = act ? BANK_OPEN : pre ? BANK_CLOSED : state_q;
    act_cnt_d = act ? 8'd0 : sat_inc8(act_cnt_q);
    pre_cnt_d = pre ? 8'd0 : sat_inc8(pre_cnt_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BANK_CLOSED;
      act_cnt_q <= 8'hff;
      pre_cnt_q <= 8'hff;
    end else begin
      state_q   <= state_d;
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end
  assign is_open = state_q == BANK_OPEN;
  assign act_cnt = act_cnt_q;
  assign pre_cnt = pre_cnt_q;
endmodule

// File: rtl/ddr3_cmd_monitor.sv
// ddr3_cmd_monitor: decodes DDR3 pins, tracks per-bank state and flags ACT/PRE/RD/WR/REF protocol violations
module ddr3_cmd_monitor
  import ddr3_mon_pkg::*;
#(
  parameter int BA_W   = 3,
  parameter int ADDR_W = 14,
  parameter int T_RCD  = 6,
  parameter int T_RP   = 6,
  parameter int T_RAS  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BA_W-1:0]      ba,
  input  logic [ADDR_W-1:0]    addr,
  output logic                 cmd_valid,
  output logic [3:0]           cmd_code,
  output logic [BA_W-1:0]      cmd_ba,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [2**BA_W-1:0]   bank_open,
  output logic                 err_valid,
  output logic [3:0]           err_code,
  output logic [BA_W-1:0]      err_ba,
  output logic [31:0]          cnt_act,
  output logic [31:0]          cnt_rd,
  output logic [31:0]          cnt_wr
);
  localparam int NB = 2**BA_W;
  localparam logic [7:0] RCD = 8'(T_RCD);
  localparam logic [7:0] RP  = 8'(T_RP);
  localparam logic [7:0] RAS = 8'(T_RAS);
  cmd_e cmd, cmd_code_q, cmd_code_d;
  err_e err_code_q, err_code_d;
  logic rw, prea_hit, tras_hit;
  logic [BA_W-1:0] prea_ba, cmd_ba_q, cmd_ba_d, err_ba_q, err_ba_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic cmd_valid_q, cmd_valid_d, err_valid_q, err_valid_d;
  logic [31:0] cnt_act_q, cnt_act_d, cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d;
  logic [7:0] act_cnt [NB];
  logic [7:0] pre_cnt [NB];
  for (genvar b = 0; b < NB; b++) begin : g_bank
    ddr3_bank_tracker u_bank (
      .clk     (clk),
      .rst     (rst),
      .act     (cmd == CMD_ACT && ba == BA_W'(b)),
      .pre     (cmd == CMD_PREA || (cmd == CMD_PRE && ba == BA_W'(b))),
      .is_open (bank_open[b]),
      .act_cnt (act_cnt[b]),
      .pre_cnt (pre_cnt[b])
    );
  end
  always_comb begin
    cmd      = decode_cmd(cke, cs_n, ras_n, cas_n, we_n, addr[10]);
    rw       = cmd == CMD_RD || cmd == CMD_WR;
    prea_hit = 1'b0;
    prea_ba  = '0;
    for (int i = NB - 1; i >= 0; i--)
      if (bank_open[i] && act_cnt[i] < RAS) begin
        prea_hit = 1'b1;
        prea_ba  = BA_W'(i);
      end
    tras_hit    = cmd == CMD_PREA ? prea_hit : cmd == CMD_PRE && bank_open[ba] && act_cnt[ba] < RAS;
    err_code_d  = cmd == CMD_ACT && bank_open[ba]  ? ERR_ACT_OPEN  :
                  rw && !bank_open[ba]             ? ERR_RW_CLOSED :
                  cmd == CMD_REF && |bank_open     ? ERR_REF_OPEN  :
                  rw && act_cnt[ba] < RCD          ? ERR_TRCD      :
                  cmd == CMD_ACT && pre_cnt[ba] < RP ? ERR_TRP     :
                  tras_hit                         ? ERR_TRAS      : ERR_NONE;
    err_valid_d = err_code_d != ERR_NONE;
    err_ba_d    = cmd == CMD_PREA ? prea_ba : ba;
    cmd_valid_d = cmd != CMD_NOP;
    cmd_code_d  = cmd;
    cmd_ba_d    = ba;
    cmd_addr_d  = addr;
    cnt_act_d   = sat_inc32(cnt_act_q, cmd == CMD_ACT);
    cnt_rd_d    = sat_inc32(cnt_rd_q, cmd == CMD_RD);
    cnt_wr_d    = sat_inc32(cnt_wr_q, cmd == CMD_WR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NOP;
      cmd_ba_q    <= '0;
      cmd_addr_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_ba_q    <= '0;
      cnt_act_q   <= '0;
      cnt_rd_q    <= '0;
      cnt_wr_q    <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_addr_q  <= cmd_addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_ba_q    <= err_ba_d;
      cnt_act_q   <= cnt_act_d;
      cnt_rd_q    <= cnt_rd_d;
      cnt_wr_q    <= cnt_wr_d;
    end
  end
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_addr  = cmd_addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_ba    = err_ba_q;
  assign cnt_act   = cnt_act_q;
  assign cnt_rd    = cnt_rd_q;
  assign cnt_wr    = cnt_wr_q;
endmodule

// File: tb/tb_ddr3_cmd_monitor.sv
// tb_ddr3_cmd_monitor: directed scenarios with hand-computed expectations for the DDR3 command monitor
module tb_ddr3_cmd_monitor;
  import ddr3_mon_pkg::*;
  localparam logic [2:0] P_ACT = 3'b011, P_RD = 3'b101, P_WR = 3'b100, P_PRE = 3'b010, P_REF = 3'b001, P_NOP = 3'b111;
  logic clk = 1'b0, rst = 1'b1, cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0] ba = '0;
  logic [13:0] addr = '0;
  logic cmd_valid, err_valid;
  logic [3:0] cmd_code, err_code;
  logic [2:0] cmd_ba, err_ba;
  logic [13:0] cmd_addr;
  logic [7:0] bank_open;
  logic [31:0] cnt_act, cnt_rd, cnt_wr;
  int errs = 0, checks = 0;
  ddr3_cmd_monitor dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr), .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code),
    .err_ba(err_ba), .cnt_act(cnt_act), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic [2:0] rcw, input logic [2:0] b, input logic [13:0] a);
    {ras_n, cas_n, we_n} = rcw; ba = b; addr = a; cs_n = 1'b0; cke = 1'b1;
    @(posedge clk); #1;
    {ras_n, cas_n, we_n} = P_NOP; cs_n = 1'b1;
  endtask
  task automatic nops(input int n);
    repeat (n) cyc(P_NOP, 3'd0, 14'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    checks++; if (err_valid !== 1'b0) begin errs++; $display("FAIL reset_err_valid got %b exp 0", err_valid); end
    checks++; if (cmd_code !== CMD_NOP) begin errs++; $display("FAIL reset_cmd_code got %0d exp %0d", cmd_code, CMD_NOP); end
    checks++; if (err_code !== ERR_NONE) begin errs++; $display("FAIL reset_err_code got %0d exp %0d", err_code, ERR_NONE); end
    checks++; if (bank_open !== 8'h00) begin errs++; $display("FAIL reset_bank_open got %h exp 00", bank_open); end
    checks++; if ({cnt_act, cnt_rd, cnt_wr} !== 96'd0) begin errs++; $display("FAIL reset_counters got %0d/%0d/%0d exp 0", cnt_act, cnt_rd, cnt_wr); end
  endtask
  task automatic test_act_rd();
    cyc(P_ACT, 3'd2, 14'h1A5);
    checks++; if (cmd_valid !== 1'b1 || cmd_code !== CMD_ACT) begin errs++; $display("FAIL act_pulse got v=%b c=%0d exp v=1 c=%0d", cmd_valid, cmd_code, CMD_ACT); end
    checks++; if (cmd_ba !== 3'd2 || cmd_addr !== 14'h1A5) begin errs++; $display("FAIL act_fields got ba=%0d a=%h exp ba=2 a=1a5", cmd_ba, cmd_addr); end
    checks++; if (bank_open !== 8'h04) begin errs++; $display("FAIL act_bank_open got %h exp 04", bank_open); end
    nops(6);
    checks++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL nop_no_pulse got %b exp 0", cmd_valid); end
    cyc(P_RD, 3'd2, 14'h040);
    checks++; if (cmd_code !== CMD_RD || cmd_addr !== 14'h040) begin errs++; $display("FAIL rd_cmd got c=%0d a=%h exp c=%0d a=040", cmd_code, cmd_addr, CMD_RD); end
    checks++; if (err_valid !== 1'b0) begin errs++; $display("FAIL rd_no_err got %b code %0d exp 0", err_valid, err_code); end
    checks++; if (cnt_act !== 32'd1 || cnt_rd !== 32'd1) begin errs++; $display("FAIL rd_counts got act=%0d rd=%0d exp 1/1", cnt_act, cnt_rd); end
    checks++; if (bank_open !== 8'h04) begin errs++; $display("FAIL rd_bank_open got %h exp 04", bank_open); end
  endtask
  task automatic test_trcd();
    do_reset();
    cyc(P_ACT, 3'd1, 14'h0);
    nops(2);
    cyc(P_RD, 3'd1, 14'h0);
    checks++; if (err_valid !== 1'b1 || err_code !== ERR_TRCD || err_ba !== 3'd1) begin errs++; $display("FAIL trcd got v=%b c=%0d ba=%0d exp 1/%0d/1", err_valid, err_code, err_ba, ERR_TRCD); end
    nops(1);
    checks++; if (err_valid !== 1'b0) begin errs++; $display("FAIL trcd_pulse got %b exp 0", err_valid); end
    do_reset();
    cyc(P_ACT, 3'd0, 14'h0);
    nops(5);
    cyc(P_WR, 3'd0, 14'h0);
    checks++; if (err_code !== ERR_TRCD || cnt_wr !== 32'd1) begin errs++; $display("FAIL trcd_edge got c=%0d wr=%0d exp %0d/1", err_code, cnt_wr, ERR_TRCD); end
  endtask
  task automatic test_rw_closed();
    do_reset();
    cyc(P_WR, 3'd5, 14'h10);
    checks++; if (err_valid !== 1'b1 || err_code !== ERR_RW_CLOSED || err_ba !== 3'd5) begin errs++; $display("FAIL rw_closed got v=%b c=%0d ba=%0d exp 1/%0d/5", err_valid, err_code, err_ba, ERR_RW_CLOSED); end
    checks++; if (bank_open !== 8'h00) begin errs++; $display("FAIL rw_closed_open got %h exp 00", bank_open); end
  endtask
  task automatic test_prea_ref();
    do_reset();
    cyc(P_ACT, 3'd0, 14'h0);
    cyc(P_ACT, 3'd3, 14'h0);
    nops(20);
    checks++; if (bank_open !== 8'h09) begin errs++; $display("FAIL prea_pre_open got %h exp 09", bank_open); end
    cyc(P_PRE, 3'd0, 14'h400);
    checks++; if (cmd_code !== CMD_PREA || bank_open !== 8'h00 || err_valid !== 1'b0) begin errs++; $display("FAIL prea got c=%0d open=%h e=%b exp %0d/00/0", cmd_code, bank_open, err_valid, CMD_PREA); end
    cyc(P_REF, 3'd0, 14'h0);
    checks++; if (cmd_code !== CMD_REF || err_valid !== 1'b0) begin errs++; $display("FAIL ref_closed got c=%0d e=%b exp %0d/0", cmd_code, err_valid, CMD_REF); end
    do_reset();
    cyc(P_ACT, 3'd6, 14'h0);
    cyc(P_ACT, 3'd2, 14'h0);
    nops(14);
    cyc(P_PRE, 3'd0, 14'h400);
    checks++; if (err_code !== ERR_TRAS || err_ba !== 3'd2 || bank_open !== 8'h00) begin errs++; $display("FAIL prea_tras got c=%0d ba=%0d open=%h exp %0d/2/00", err_code, err_ba, bank_open, ERR_TRAS); end
  endtask
  task automatic test_ref_tras_trp();
    do_reset();
    cyc(P_ACT, 3'd4, 14'h0);
    nops(1);
    cyc(P_REF, 3'd0, 14'h0);
    checks++; if (err_code !== ERR_REF_OPEN || bank_open !== 8'h10) begin errs++; $display("FAIL ref_open got c=%0d open=%h exp %0d/10", err_code, bank_open, ERR_REF_OPEN); end
    nops(7);
    cyc(P_PRE, 3'd4, 14'h0);
    checks++; if (err_code !== ERR_TRAS || err_ba !== 3'd4 || bank_open !== 8'h00) begin errs++; $display("FAIL tras got c=%0d ba=%0d open=%h exp %0d/4/00", err_code, err_ba, bank_open, ERR_TRAS); end
    cyc(P_ACT, 3'd4, 14'h0);
    checks++; if (err_code !== ERR_TRP || err_ba !== 3'd4 || bank_open !== 8'h10) begin errs++; $display("FAIL trp got c=%0d ba=%0d open=%h exp %0d/4/10", err_code, err_ba, bank_open, ERR_TRP); end
    do_reset();
    cyc(P_ACT, 3'd3, 14'h0);
    nops(15);
    cyc(P_PRE, 3'd3, 14'h0);
    checks++; if (err_valid !== 1'b0 || bank_open !== 8'h00) begin errs++; $display("FAIL tras_edge got e=%b open=%h exp 0/00", err_valid, bank_open); end
    cyc(P_PRE, 3'd7, 14'h0);
    checks++; if (err_valid !== 1'b0 || cmd_code !== CMD_PRE) begin errs++; $display("FAIL pre_closed got e=%b c=%0d exp 0/%0d", err_valid, cmd_code, CMD_PRE); end
    cyc(P_ACT, 3'd7, 14'h0);
    checks++; if (err_code !== ERR_TRP || err_ba !== 3'd7) begin errs++; $display("FAIL pre_closed_trp got c=%0d ba=%0d exp %0d/7", err_code, err_ba, ERR_TRP); end
  endtask
  task automatic test_act_open();
    do_reset();
    cyc(P_ACT, 3'd2, 14'h0);
    cyc(P_ACT, 3'd2, 14'h0);
    checks++; if (err_code !== ERR_ACT_OPEN || bank_open !== 8'h04 || cnt_act !== 32'd2) begin errs++; $display("FAIL act_open got c=%0d open=%h act=%0d exp %0d/04/2", err_code, bank_open, cnt_act, ERR_ACT_OPEN); end
    cyc(P_RD, 3'd2, 14'h0);
    checks++; if (err_code !== ERR_TRCD) begin errs++; $display("FAIL act_open_restart got c=%0d exp %0d", err_code, ERR_TRCD); end
    {ras_n, cas_n, we_n} = P_ACT; ba = 3'd5; cs_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b0 || bank_open !== 8'h04) begin errs++; $display("FAIL deselect got v=%b open=%h exp 0/04", cmd_valid, bank_open); end
    cs_n = 1'b0; cke = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b0 || bank_open !== 8'h04) begin errs++; $display("FAIL cke_low got v=%b open=%h exp 0/04", cmd_valid, bank_open); end
    cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP;
  endtask
  task automatic test_reset_mid();
    do_reset();
    cyc(P_ACT, 3'd6, 14'h0);
    checks++; if (bank_open !== 8'h40) begin errs++; $display("FAIL mid_act_open got %h exp 40", bank_open); end
    {ras_n, cas_n, we_n} = P_WR; ba = 3'd6; cs_n = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; {ras_n, cas_n, we_n} = P_NOP; cs_n = 1'b1;
    checks++; if (cmd_valid !== 1'b0 || err_valid !== 1'b0 || bank_open !== 8'h00) begin errs++; $display("FAIL mid_rst got v=%b e=%b open=%h exp 0/0/00", cmd_valid, err_valid, bank_open); end
    checks++; if ({cnt_act, cnt_rd, cnt_wr} !== 96'd0) begin errs++; $display("FAIL mid_rst_cnt got %0d/%0d/%0d exp 0", cnt_act, cnt_rd, cnt_wr); end
    cyc(P_ACT, 3'd6, 14'h0);
    checks++; if (err_valid !== 1'b0 || bank_open !== 8'h40 || cnt_act !== 32'd1) begin errs++; $display("FAIL mid_react got e=%b open=%h act=%0d exp 0/40/1", err_valid, bank_open, cnt_act); end
  endtask
  initial begin
    test_reset();
    test_act_rd();
    test_trcd();
    test_rw_closed();
    test_prea_ref();
    test_ref_tras_trp();
    test_act_open();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
